// File: rtl/fetch_pkg.sv
// Shared types and defaults for the instruction-fetch sequencer.
package fetch_pkg;

    // Sequencer states: waiting for start, fetching, parked on a halt word.
    typedef enum logic [1:0] {
        FS_IDLE   = 2'd0,
        FS_FETCH  = 2'd1,
        FS_HALTED = 2'd2
    } fetch_state_e;

    // Instruction word that stops fetching.
    localparam logic [31:0] DEFAULT_HALT_WORD  = 32'hFFFF_FFFF;
    // Word address loaded into the PC on start.
    localparam int          DEFAULT_START_ADDR = 0;

endpackage

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: holds the PC, addresses the combinational
// instruction memory and registers each fetched word into a one-entry
// output stage toward decode.
//
// Handshake toward decode: if_valid means if_inst/if_pc hold an instruction.
// A transfer happens on a rising edge where if_valid && if_ready are both high.
// While if_valid && !if_ready, if_inst and if_pc stay stable. if_valid is
// never dropped without a transfer, except by a redirect flush or by reset.
module fetch_ctrl
    import fetch_pkg::*;
#(
    parameter int              AW         = 5,
    parameter int              DW         = 32,
    parameter int              START_ADDR = DEFAULT_START_ADDR,
    parameter logic [DW-1:0]   HALT_WORD  = DW'(DEFAULT_HALT_WORD),
    parameter int              CW         = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               redirect_valid,
    input  logic [AW-1:0]      redirect_addr,
    output logic [AW-1:0]      im_addr,
    input  logic [DW-1:0]      im_inst,
    output logic               if_valid,
    input  logic               if_ready,
    output logic [DW-1:0]      if_inst,
    output logic [AW-1:0]      if_pc,
    output logic               halted,
    output logic [CW-1:0]      fetch_count,
    output fetch_state_e       dbg_state
);

    localparam logic [AW-1:0] START_PC = AW'(START_ADDR);

    fetch_state_e  state;
    logic [AW-1:0] pc;
    logic          slot_free;
    logic          consume;

    // The output stage can take a new word when empty or when it drains this edge.
    assign slot_free = !if_valid || if_ready;
    assign consume   = if_valid && if_ready;

    // Memory address comes straight from the PC register.
    assign im_addr   = pc;
    assign dbg_state = state;

    // Sequencer FSM, PC, output stage and delivered-instruction counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= FS_IDLE;
            pc          <= START_PC;
            if_valid    <= 1'b0;
            if_inst     <= '0;
            if_pc       <= '0;
            halted      <= 1'b0;
            fetch_count <= '0;
        end else begin
            // Counts every transfer regardless of state; sticks at all-ones.
            if (consume && (fetch_count != '1)) begin
                fetch_count <= fetch_count + 1'b1;
            end

            case (state)
                FS_IDLE: begin
                    if (consume) begin
                        if_valid <= 1'b0;
                    end
                    // Redirects are meaningless before the first start.
                    if (start) begin
                        pc    <= START_PC;
                        state <= FS_FETCH;
                    end
                end

                FS_FETCH: begin
                    if (redirect_valid) begin
                        // Flush wins even over a same-edge transfer; the
                        // transferred word is still counted above.
                        pc       <= redirect_addr;
                        if_valid <= 1'b0;
                    end else if (slot_free) begin
                        if_inst  <= im_inst;
                        if_pc    <= pc;
                        if_valid <= 1'b1;
                        if (im_inst == HALT_WORD) begin
                            // Halt word is delivered; PC parks on it.
                            state  <= FS_HALTED;
                            halted <= 1'b1;
                        end else begin
                            pc <= pc + 1'b1;
                        end
                    end
                end

                FS_HALTED: begin
                    // Pending halt word may still drain to decode.
                    if (consume) begin
                        if_valid <= 1'b0;
                    end
                    if (redirect_valid) begin
                        pc       <= redirect_addr;
                        if_valid <= 1'b0;
                        halted   <= 1'b0;
                        state    <= FS_FETCH;
                    end else if (start) begin
                        pc     <= START_PC;
                        halted <= 1'b0;
                        state  <= FS_FETCH;
                    end
                end

                default: begin
                    state <= FS_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl with a behavioural 32x32 instruction memory.
module tb_fetch_ctrl;
    import fetch_pkg::*;

    localparam logic [31:0] HALT = 32'hFFFF_FFFF;
    localparam int          EW   = 37;

    logic         clk;
    logic         reset;
    logic         start;
    logic         redirect_valid;
    logic [4:0]   redirect_addr;
    logic [4:0]   im_addr;
    logic [31:0]  im_inst;
    logic         if_valid;
    logic         if_ready;
    logic [31:0]  if_inst;
    logic [4:0]   if_pc;
    logic         halted;
    logic [15:0]  fetch_count;
    fetch_state_e dbg_state;

    logic [31:0]  mem [32];

    int checks;
    int failures;

    // Reference stream: {pc, inst} words decode must see, in order.
    logic [EW-1:0] exp_q[$];
    bit            started;
    int            pops;

    fetch_ctrl dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .redirect_valid (redirect_valid),
        .redirect_addr  (redirect_addr),
        .im_addr        (im_addr),
        .im_inst        (im_inst),
        .if_valid       (if_valid),
        .if_ready       (if_ready),
        .if_inst        (if_inst),
        .if_pc          (if_pc),
        .halted         (halted),
        .fetch_count    (fetch_count),
        .dbg_state      (dbg_state)
    );

    // Combinational-read instruction memory.
    assign im_inst = mem[im_addr];

    // Clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: inputs change and outputs are sampled at the falling edge.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic load_default_mem();
        for (int i = 0; i < 32; i++) mem[i] = 32'(100 + i);
        mem[0] = 32'd10;
        mem[1] = 32'd11;
        mem[2] = 32'd12;
        mem[3] = 32'd13;
    endtask

    task automatic check_out(input string tag, input logic [31:0] inst, input logic [4:0] pcv);
        check({tag, "_valid"}, 64'(if_valid), 64'(1));
        check({tag, "_inst"}, 64'(if_inst), 64'(inst));
        check({tag, "_pc"}, 64'(if_pc), 64'(pcv));
    endtask

    // Program order from address a up to and including the first halt word.
    task automatic refill(input logic [4:0] a);
        exp_q.delete();
        for (int i = 0; i < 32; i++) begin
            logic [4:0] ad;
            ad = a + 5'(i);
            exp_q.push_back({ad, mem[ad]});
            if (mem[ad] == HALT) break;
        end
    endtask

    // One reference-checked cycle with whatever inputs are currently driven.
    task automatic model_step();
        logic [EW-1:0] e;
        if (if_valid && if_ready) begin
            check("stream_pending", 64'(exp_q.size() > 0), 64'(1));
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                pops++;
                check("stream_word", 64'({if_pc, if_inst}), 64'(e));
            end
        end
        tick();
        if (started && redirect_valid) begin
            refill(redirect_addr);
        end else if (start && (!started || exp_q.size() == 0)) begin
            refill(5'(DEFAULT_START_ADDR));
            started = 1'b1;
        end else if (started && exp_q.size() == 0) begin
            check("done_halted", 64'(halted), 64'(1));
            check("done_empty", 64'(if_valid), 64'(0));
        end
    endtask

    task automatic random_round(input int cycles);
        int h;
        h = $urandom_range(0, 31);
        for (int i = 0; i < 32; i++) begin
            mem[i] = $urandom;
            if (mem[i] == HALT) mem[i] = 32'h0;
        end
        mem[h] = HALT;
        do_reset();
        exp_q.delete();
        started = 1'b0;
        pops = 0;
        // Redirects before start must be ignored.
        for (int i = 0; i < 4; i++) begin
            if_ready = 1'b1;
            redirect_valid = ($urandom_range(0, 1) == 1);
            redirect_addr = 5'($urandom_range(0, 31));
            start = 1'b0;
            model_step();
        end
        start = 1'b1;
        redirect_valid = 1'b0;
        model_step();
        for (int i = 0; i < cycles; i++) begin
            if_ready = ($urandom_range(0, 9) < 7);
            redirect_valid = ($urandom_range(0, 15) == 0);
            redirect_addr = 5'($urandom_range(0, 31));
            start = (exp_q.size() == 0) && ($urandom_range(0, 3) == 0);
            model_step();
        end
        start = 1'b0;
        redirect_valid = 1'b0;
        if_ready = 1'b1;
        for (int i = 0; i < 100 && exp_q.size() != 0; i++) model_step();
        check("round_drained", 64'(exp_q.size()), 64'(0));
        check("round_count", 64'(fetch_count), 64'(pops));
    endtask

    initial begin
        checks = 0;
        failures = 0;
        reset = 1'b1;
        start = 1'b0;
        redirect_valid = 1'b0;
        redirect_addr = '0;
        if_ready = 1'b0;
        load_default_mem();
        @(negedge clk);

        // Reset values.
        do_reset();
        check("rst_valid", 64'(if_valid), 64'(0));
        check("rst_inst", 64'(if_inst), 64'(0));
        check("rst_pc", 64'(if_pc), 64'(0));
        check("rst_halted", 64'(halted), 64'(0));
        check("rst_count", 64'(fetch_count), 64'(0));
        check("rst_addr", 64'(im_addr), 64'(0));
        check("rst_state", 64'(dbg_state), 64'(FS_IDLE));

        // Start and streaming at one word per cycle.
        start = 1'b1;
        if_ready = 1'b1;
        tick();
        start = 1'b0;
        check("start_no_capture", 64'(if_valid), 64'(0));
        check("start_state", 64'(dbg_state), 64'(FS_FETCH));
        tick();
        for (int k = 0; k < 4; k++) begin
            check_out("stream", 32'(10 + k), 5'(k));
            check("stream_count", 64'(fetch_count), 64'(k));
            tick();
        end
        check("stream_count4", 64'(fetch_count), 64'(4));

        // Backpressure holds the output stage and PC.
        redirect_valid = 1'b1;
        redirect_addr = 5'd0;
        tick();
        redirect_valid = 1'b0;
        check("bp_flush", 64'(if_valid), 64'(0));
        check("bp_flush_count", 64'(fetch_count), 64'(5));
        tick();
        tick();
        check_out("bp_pre", 32'd11, 5'd1);
        if_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            check_out("bp_hold", 32'd11, 5'd1);
            check("bp_hold_addr", 64'(im_addr), 64'(2));
        end
        if_ready = 1'b1;
        tick();
        check_out("bp_release", 32'd12, 5'd2);
        check("bp_count", 64'(fetch_count), 64'(7));

        // Redirect flushes even with a same-edge transfer.
        redirect_valid = 1'b1;
        redirect_addr = 5'd20;
        tick();
        redirect_valid = 1'b0;
        check("rd_flush", 64'(if_valid), 64'(0));
        check("rd_count", 64'(fetch_count), 64'(8));
        tick();
        check_out("rd_target", 32'd120, 5'd20);

        // Halt word at address 5 is delivered, then fetching stops.
        mem[5] = HALT;
        redirect_valid = 1'b1;
        redirect_addr = 5'd3;
        tick();
        redirect_valid = 1'b0;
        tick();
        tick();
        tick();
        check_out("halt_word", HALT, 5'd5);
        check("halt_flag", 64'(halted), 64'(1));
        check("halt_state", 64'(dbg_state), 64'(FS_HALTED));
        for (int k = 0; k < 10; k++) begin
            tick();
            check("halt_idle_valid", 64'(if_valid), 64'(0));
            check("halt_idle_addr", 64'(im_addr), 64'(5));
        end
        check("halt_count", 64'(fetch_count), 64'(12));
        start = 1'b1;
        tick();
        start = 1'b0;
        check("resume_halted", 64'(halted), 64'(0));
        check("resume_addr", 64'(im_addr), 64'(0));
        tick();
        check_out("resume_first", 32'd10, 5'd0);

        // Wrap from 31 to 0; start while fetching is ignored.
        redirect_valid = 1'b1;
        redirect_addr = 5'd30;
        tick();
        redirect_valid = 1'b0;
        tick();
        check_out("wrap30", 32'd130, 5'd30);
        tick();
        check_out("wrap31", 32'd131, 5'd31);
        start = 1'b1;
        tick();
        start = 1'b0;
        check_out("wrap0", 32'd10, 5'd0);
        tick();
        check_out("wrap1", 32'd11, 5'd1);

        // Reset during a stall discards the output stage.
        if_ready = 1'b0;
        tick();
        check("stall_valid", 64'(if_valid), 64'(1));
        do_reset();
        check("mid_rst_valid", 64'(if_valid), 64'(0));
        check("mid_rst_state", 64'(dbg_state), 64'(FS_IDLE));
        check("mid_rst_count", 64'(fetch_count), 64'(0));
        redirect_valid = 1'b1;
        redirect_addr = 5'd7;
        tick();
        redirect_valid = 1'b0;
        check("idle_redirect_addr", 64'(im_addr), 64'(0));
        check("idle_redirect_state", 64'(dbg_state), 64'(FS_IDLE));
        if_ready = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        check_out("restart0", 32'd10, 5'd0);
        tick();
        check_out("restart1", 32'd11, 5'd1);

        // Randomized traffic against the program-order reference stream.
        for (int r = 0; r < 3; r++) random_round(600);

        // Counter saturation.
        start = 1'b0;
        redirect_valid = 1'b0;
        load_default_mem();
        do_reset();
        if_ready = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (65535) tick();
        check("sat_below", 64'(fetch_count), 64'(16'hFFFE));
        tick();
        check("sat_top", 64'(fetch_count), 64'(16'hFFFF));
        repeat (5) tick();
        check("sat_hold", 64'(fetch_count), 64'(16'hFFFF));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
